load_store_unit: RTL and testbench

Data-memory access unit for the M1/M2 memory stages of the pipelined core. It turns M1 load/store operations into single-beat data-bus requests with byte enables, tracks one outstanding load, and returns sign/zero-extended load data in M2. It raises a pipeline-wide stall whenever the bus back-pressures a request or a load response is late. This is the producer side of the M2 load result that the decode-stage load-use hazard logic waits on.

---
 rtl/load_store_unit_if.sv | 45 ++++
 rtl/load_store_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_pkg / load_store_unit_if
//
// Purpose: shared memory-access type plus the single-beat data-bus bundle
// between the load/store unit (master) and the data memory (slave).
//
// Signals:
//   dbus_req_valid  master->slave  request valid
//   dbus_req_ready  slave->master  request accepted this cycle
//   dbus_req_we     master->slave  1 = write
//   dbus_req_addr   master->slave  word-aligned byte address
//   dbus_req_wdata  master->slave  lane-replicated store data
//   dbus_req_be     master->slave  byte enables
//   dbus_resp_valid slave->master  read data valid (in order, one outstanding)
//   dbus_resp_rdata slave->master  read word

package load_store_unit_pkg;
  typedef enum logic [1:0] {
    MEM_DISABLED = 2'b00,
    MEM_READ     = 2'b01,
    MEM_WRITE    = 2'b10
  } memaccess_t;
endpackage

interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            dbus_req_valid;
  logic            dbus_req_ready;
  logic            dbus_req_we;
  logic [XLEN-1:0] dbus_req_addr;
  logic [XLEN-1:0] dbus_req_wdata;
  logic [3:0]      dbus_req_be;
  logic            dbus_resp_valid;
  logic [XLEN-1:0] dbus_resp_rdata;

  modport master (
    output dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_be,
    input  dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
  );

  modport slave (
    input  dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_be,
    output dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Purpose: M1/M2 data-memory access unit. Turns M1 load/store ops into
// single-beat bus requests with byte enables, tracks one outstanding load,
// returns sign/zero-extended load data in M2 and stalls the pipeline on bus
// back-pressure or a late load response.
//
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned half/word
// accesses on o_misalign_m1 (no request issued). Without it the address is
// truncated and the access proceeds.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   i_memaccess_m1      MEM_READ / MEM_WRITE / MEM_DISABLED for M1
//   i_funct3_m1         width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   i_addr_m1           byte address
//   i_wdata_m1          right-aligned store data
//   dbus                data-bus master modport
//   o_rdata_m2          extended load result
//   o_rdata_valid_m2    o_rdata_m2 valid this cycle
//   o_stall_mem         freeze F/D/E/M1 (and M2 while waiting)
//   o_misalign_m1       misaligned access (MISALIGN_TRAP_EN only)
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no request held, no load outstanding
// HOLD  | request presented, not yet accepted
// WAIT  | load accepted, response pending

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  memaccess_t         i_memaccess_m1,
  input  logic [2:0]         i_funct3_m1,
  input  logic [XLEN-1:0]    i_addr_m1,
  input  logic [XLEN-1:0]    i_wdata_m1,
  load_store_unit_if.master  dbus,
  output logic [XLEN-1:0]    o_rdata_m2,
  output logic               o_rdata_valid_m2,
  output logic               o_stall_mem,
  output logic               o_misalign_m1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_hold_we;
  logic [XLEN-1:0] r_hold_addr;
  logic [XLEN-1:0] r_hold_wdata;
  logic [3:0]      r_hold_be;
  logic [1:0]      r_ld_off;
  logic [2:0]      r_ld_funct3;

  logic            w_latch_ld;
  logic            w_latch_hold;
  logic            w_new_slot;

  // ---------------- M1 request decode ----------------
  logic            w_is_load;
  logic            w_active;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_misalign;
  logic            w_issue;
  logic [3:0]      w_m1_be;
  logic [XLEN-1:0] w_m1_wdata;
  logic [XLEN-1:0] w_m1_addr;

  assign w_is_load = (i_memaccess_m1 == MEM_READ);
  assign w_active  = (i_memaccess_m1 == MEM_READ) || (i_memaccess_m1 == MEM_WRITE);

  // funct3[2] only means "unsigned" for loads; stores with 1xx are unused
  // codes and fall back to the word form.
  assign w_is_byte = (i_funct3_m1[1:0] == 2'b00) && (w_is_load || !i_funct3_m1[2]);
  assign w_is_half = (i_funct3_m1[1:0] == 2'b01) && (w_is_load || !i_funct3_m1[2]);
  assign w_is_word = !w_is_byte && !w_is_half;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_active &&
                      ((w_is_half && i_addr_m1[0]) ||
                       (w_is_word && (i_addr_m1[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = w_active && !w_misalign;
  assign w_m1_addr = {i_addr_m1[XLEN-1:2], 2'b00};

  always_comb begin
    w_m1_be    = 4'b1111;
    w_m1_wdata = i_wdata_m1;
    if (w_is_byte) begin
      w_m1_be    = 4'b0001 << i_addr_m1[1:0];
      w_m1_wdata = {(XLEN/8){i_wdata_m1[7:0]}};
    end else if (w_is_half) begin
      w_m1_be    = i_addr_m1[1] ? 4'b1100 : 4'b0011;
      w_m1_wdata = {(XLEN/16){i_wdata_m1[15:0]}};
    end
  end

  // ---------------- Load formatting ----------------
  logic [XLEN-1:0] w_byte_shift;
  logic [XLEN-1:0] w_half_shift;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;

  assign w_byte_shift = dbus.dbus_resp_rdata >> {r_ld_off, 3'b000};
  assign w_half_shift = dbus.dbus_resp_rdata >> {r_ld_off[1], 4'b0000};
  assign w_ld_byte    = w_byte_shift[7:0];
  assign w_ld_half    = w_half_shift[15:0];

  always_comb begin
    case (r_ld_funct3)
      3'b000:  o_rdata_m2 = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'b001:  o_rdata_m2 = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      3'b100:  o_rdata_m2 = {{(XLEN-8){1'b0}}, w_ld_byte};
      3'b101:  o_rdata_m2 = {{(XLEN-16){1'b0}}, w_ld_half};
      default: o_rdata_m2 = dbus.dbus_resp_rdata;
    endcase
  end

  // ---------------- FSM next-state / outputs ----------------
  always_comb begin
    w_next              = r_state;
    dbus.dbus_req_valid = 1'b0;
    dbus.dbus_req_we    = 1'b0;
    dbus.dbus_req_addr  = '0;
    dbus.dbus_req_wdata = '0;
    dbus.dbus_req_be    = 4'b0000;
    o_rdata_valid_m2    = 1'b0;
    o_stall_mem         = 1'b0;
    o_misalign_m1       = 1'b0;
    w_latch_ld          = 1'b0;
    w_latch_hold        = 1'b0;
    w_new_slot          = 1'b0;

    // Outputs are forced quiet during reset so nothing leaks onto the bus
    // while the state register is being cleared.
    if (reset) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_new_slot = 1'b1;
        HOLD: begin
          dbus.dbus_req_valid = 1'b1;
          dbus.dbus_req_we    = r_hold_we;
          dbus.dbus_req_addr  = r_hold_addr;
          dbus.dbus_req_wdata = r_hold_wdata;
          dbus.dbus_req_be    = r_hold_be;
          // The accept cycle lets the held op advance, so only un-accepted
          // cycles cost a stall.
          o_stall_mem         = !dbus.dbus_req_ready;
          if (dbus.dbus_req_ready) w_next = r_hold_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (dbus.dbus_resp_valid) begin
            o_rdata_valid_m2 = 1'b1;
            w_new_slot       = 1'b1;
          end else begin
            o_stall_mem = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase

      // Shared by IDLE and a completing WAIT: the M1 op is presented now.
      if (w_new_slot) begin
        w_next        = IDLE;
        o_misalign_m1 = w_misalign;
        if (w_issue) begin
          dbus.dbus_req_valid = 1'b1;
          dbus.dbus_req_we    = !w_is_load;
          dbus.dbus_req_addr  = w_m1_addr;
          dbus.dbus_req_wdata = w_m1_wdata;
          dbus.dbus_req_be    = w_m1_be;
          if (dbus.dbus_req_ready) begin
            if (w_is_load) begin
              w_latch_ld = 1'b1;
              w_next     = WAIT;
            end
          end else begin
            o_stall_mem  = 1'b1;
            w_latch_ld   = 1'b1;
            w_latch_hold = 1'b1;
            w_next       = HOLD;
          end
        end
      end
    end
  end

  // ---------------- State and latches ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_be    <= 4'b0000;
      r_ld_off     <= 2'b00;
      r_ld_funct3  <= 3'b000;
    end else begin
      r_state <= w_next;
      if (w_latch_ld) begin
        r_ld_off    <= i_addr_m1[1:0];
        r_ld_funct3 <= i_funct3_m1;
      end
      if (w_latch_hold) begin
        r_hold_we    <= !w_is_load;
        r_hold_addr  <= w_m1_addr;
        r_hold_wdata <= w_m1_wdata;
        r_hold_be    <= w_m1_be;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  memaccess_t  memaccess;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_m2;
  logic        rdata_valid_m2;
  logic        stall_mem;
  logic        misalign_m1;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) dbus ();

  load_store_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_memaccess_m1   (memaccess),
    .i_funct3_m1      (funct3),
    .i_addr_m1        (addr),
    .i_wdata_m1       (wdata),
    .dbus             (dbus),
    .o_rdata_m2       (rdata_m2),
    .o_rdata_valid_m2 (rdata_valid_m2),
    .o_stall_mem      (stall_mem),
    .o_misalign_m1    (misalign_m1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic m1(input memaccess_t a, input logic [2:0] f, input logic [31:0] ad,
                    input logic [31:0] wd);
    memaccess = a;
    funct3    = f;
    addr      = ad;
    wdata     = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load followed by its response one cycle later.
  task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] ad,
                         input logic [31:0] resp, input logic [31:0] exp);
    tick();
    m1(MEM_READ, f, ad, 32'h0);
    #1;
    check({tag, "_req_valid"}, 32'(dbus.dbus_req_valid), 32'd1);
    check({tag, "_req_we"}, 32'(dbus.dbus_req_we), 32'd0);
    check({tag, "_req_stall"}, 32'(stall_mem), 32'd0);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    dbus.dbus_resp_valid = 1'b1;
    dbus.dbus_resp_rdata = resp;
    #1;
    check({tag, "_rdata_valid"}, 32'(rdata_valid_m2), 32'd1);
    check({tag, "_rdata"}, rdata_m2, exp);
    check({tag, "_resp_stall"}, 32'(stall_mem), 32'd0);
    tick();
    dbus.dbus_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m1(MEM_WRITE, 3'b010, 32'h100, 32'h1);
    dbus.dbus_req_ready  = 1'b1;
    dbus.dbus_resp_valid = 1'b0;
    dbus.dbus_resp_rdata = 32'h0;
    #2;
    check("rst_req_valid", 32'(dbus.dbus_req_valid), 32'd0);
    check("rst_stall", 32'(stall_mem), 32'd0);
    check("rst_req_be", 32'(dbus.dbus_req_be), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    #1;
    check("idle_req_valid", 32'(dbus.dbus_req_valid), 32'd0);
    check("idle_stall", 32'(stall_mem), 32'd0);
    check("idle_rdata_valid", 32'(rdata_valid_m2), 32'd0);
    check("idle_misalign", 32'(misalign_m1), 32'd0);

    // SW
    tick();
    m1(MEM_WRITE, 3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    check("sw_valid", 32'(dbus.dbus_req_valid), 32'd1);
    check("sw_we", 32'(dbus.dbus_req_we), 32'd1);
    check("sw_addr", dbus.dbus_req_addr, 32'h100);
    check("sw_be", 32'(dbus.dbus_req_be), 32'hF);
    check("sw_wdata", dbus.dbus_req_wdata, 32'hDEADBEEF);
    check("sw_stall", 32'(stall_mem), 32'd0);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    #1;
    check("sw_after_valid", 32'(dbus.dbus_req_valid), 32'd0);

    // SB / SH lanes
    tick();
    m1(MEM_WRITE, 3'b000, 32'h103, 32'h000000A5);
    #1;
    check("sb_be", 32'(dbus.dbus_req_be), 32'h8);
    check("sb_wdata", dbus.dbus_req_wdata, 32'hA5A5A5A5);
    check("sb_addr", dbus.dbus_req_addr, 32'h100);
    tick();
    m1(MEM_WRITE, 3'b001, 32'h102, 32'h00001234);
    #1;
    check("sh_be", 32'(dbus.dbus_req_be), 32'hC);
    check("sh_wdata", dbus.dbus_req_wdata, 32'h12341234);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);

    // Load formatting
    do_load("lb",  3'b000, 32'h102, 32'h80FF7F00, 32'hFFFFFFFF);
    do_load("lbu", 3'b100, 32'h102, 32'h80FF7F00, 32'h000000FF);
    do_load("lh",  3'b001, 32'h102, 32'h80FF7F00, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'h100, 32'h80FF7F00, 32'h00007F00);
    do_load("lw",  3'b010, 32'h100, 32'h80FF7F00, 32'h80FF7F00);

    // LH with two ready=0 cycles and a response 3 cycles after accept
    stall_cnt = 0;
    tick();
    m1(MEM_READ, 3'b001, 32'h100, 32'h0);
    dbus.dbus_req_ready = 1'b0;
    #1;
    check("hold0_valid", 32'(dbus.dbus_req_valid), 32'd1);
    check("hold0_stall", 32'(stall_mem), 32'd1);
    stall_cnt += int'(stall_mem);
    tick();
    m1(MEM_WRITE, 3'b000, 32'h3FC, 32'hFF);
    #1;
    check("hold1_addr", dbus.dbus_req_addr, 32'h100);
    check("hold1_we", 32'(dbus.dbus_req_we), 32'd0);
    check("hold1_be", 32'(dbus.dbus_req_be), 32'h3);
    check("hold1_stall", 32'(stall_mem), 32'd1);
    stall_cnt += int'(stall_mem);
    tick();
    dbus.dbus_req_ready = 1'b1;
    #1;
    check("hold2_valid", 32'(dbus.dbus_req_valid), 32'd1);
    check("hold2_addr", dbus.dbus_req_addr, 32'h100);
    stall_cnt += int'(stall_mem);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    #1;
    check("wait0_valid", 32'(dbus.dbus_req_valid), 32'd0);
    stall_cnt += int'(stall_mem);
    tick();
    #1;
    stall_cnt += int'(stall_mem);
    tick();
    dbus.dbus_resp_valid = 1'b1;
    dbus.dbus_resp_rdata = 32'hABCD8765;
    #1;
    check("lhs_rdata_valid", 32'(rdata_valid_m2), 32'd1);
    check("lhs_rdata", rdata_m2, 32'hFFFF8765);
    stall_cnt += int'(stall_mem);
    check("lhs_stall_cycles", 32'(stall_cnt), 32'd4);
    tick();
    dbus.dbus_resp_valid = 1'b0;

    // Back-to-back: response and new SW in the same cycle
    tick();
    m1(MEM_READ, 3'b010, 32'h200, 32'h0);
    #1;
    check("b2b_ld_valid", 32'(dbus.dbus_req_valid), 32'd1);
    tick();
    m1(MEM_WRITE, 3'b010, 32'h204, 32'hCAFEF00D);
    dbus.dbus_resp_valid = 1'b1;
    dbus.dbus_resp_rdata = 32'h11223344;
    #1;
    check("b2b_rdata_valid", 32'(rdata_valid_m2), 32'd1);
    check("b2b_rdata", rdata_m2, 32'h11223344);
    check("b2b_sw_valid", 32'(dbus.dbus_req_valid), 32'd1);
    check("b2b_sw_we", 32'(dbus.dbus_req_we), 32'd1);
    check("b2b_sw_addr", dbus.dbus_req_addr, 32'h204);
    check("b2b_stall", 32'(stall_mem), 32'd0);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    dbus.dbus_resp_valid = 1'b0;
    #1;
    check("b2b_after_valid", 32'(dbus.dbus_req_valid), 32'd0);
    check("b2b_after_stall", 32'(stall_mem), 32'd0);

    // Stray response in IDLE
    tick();
    dbus.dbus_resp_valid = 1'b1;
    dbus.dbus_resp_rdata = 32'h55555555;
    #1;
    check("stray_rdata_valid", 32'(rdata_valid_m2), 32'd0);
    check("stray_stall", 32'(stall_mem), 32'd0);
    tick();
    dbus.dbus_resp_valid = 1'b0;

    // Misaligned LW at 0x102
    tick();
    m1(MEM_READ, 3'b010, 32'h102, 32'h0);
    #1;
`ifdef MISALIGN_TRAP_EN
    check("mis_flag", 32'(misalign_m1), 32'd1);
    check("mis_req_valid", 32'(dbus.dbus_req_valid), 32'd0);
    check("mis_stall", 32'(stall_mem), 32'd0);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    #1;
    check("mis_after_stall", 32'(stall_mem), 32'd0);
`else
    check("mis_flag", 32'(misalign_m1), 32'd0);
    check("mis_req_valid", 32'(dbus.dbus_req_valid), 32'd1);
    check("mis_addr", dbus.dbus_req_addr, 32'h100);
    check("mis_be", 32'(dbus.dbus_req_be), 32'hF);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    dbus.dbus_resp_valid = 1'b1;
    dbus.dbus_resp_rdata = 32'h80FF7F00;
    #1;
    check("mis_rdata", rdata_m2, 32'h80FF7F00);
    tick();
    dbus.dbus_resp_valid = 1'b0;
`endif

    // Reset during WAIT abandons the load
    tick();
    m1(MEM_READ, 3'b010, 32'h300, 32'h0);
    #1;
    check("rstw_req_valid", 32'(dbus.dbus_req_valid), 32'd1);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    check("rstw_stall_in_rst", 32'(stall_mem), 32'd0);
    tick();
    reset = 1'b0;
    dbus.dbus_resp_valid = 1'b1;
    #1;
    check("rstw_rdata_valid", 32'(rdata_valid_m2), 32'd0);
    check("rstw_stall", 32'(stall_mem), 32'd0);
    tick();
    dbus.dbus_resp_valid = 1'b0;

    // Reset during HOLD drops the held request
    m1(MEM_WRITE, 3'b010, 32'h400, 32'h12345678);
    dbus.dbus_req_ready = 1'b0;
    #1;
    check("rsth_stall", 32'(stall_mem), 32'd1);
    tick();
    m1(MEM_DISABLED, 3'b000, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dbus.dbus_req_ready = 1'b1;
    #1;
    check("rsth_req_valid", 32'(dbus.dbus_req_valid), 32'd0);
    check("rsth_after_stall", 32'(stall_mem), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
